// File: rtl/inst_queue_pkg.sv
// Shared widths and entry layout for the IF->ID instruction queue.
// Entry packing, MSB to LSB: {pht_index, branch_taken, inst, pc}.
package inst_queue_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;
    localparam int unsigned GHR_W  = 8;

    typedef struct packed {
        logic [GHR_W-1:0]  pht_index;
        logic              branch_taken;
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-side and decode-side handshake bundle of the instruction queue.
// The queue uses the slave view; the surrounding pipeline drives the master view.
interface inst_queue_if;
    import inst_queue_pkg::*;

    logic              if_valid;
    logic              if_ready;
    logic              if_almost_full;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;
    logic              if_branch_taken;
    logic [GHR_W-1:0]  if_pht_index;

    logic              id_valid;
    logic              id_ready;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic              id_branch_taken;
    logic [GHR_W-1:0]  id_pht_index;

    modport slave (
        input  if_valid, if_pc, if_inst, if_branch_taken, if_pht_index, id_ready,
        output if_ready, if_almost_full,
        output id_valid, id_pc, id_inst, id_branch_taken, id_pht_index
    );

    modport master (
        output if_valid, if_pc, if_inst, if_branch_taken, if_pht_index, id_ready,
        input  if_ready, if_almost_full,
        input  id_valid, id_pc, id_inst, id_branch_taken, id_pht_index
    );

endinterface

// File: rtl/inst_queue_fifo_ctrl.sv
// Pointer/count bookkeeping for a DEPTH-entry FIFO with flush; no data path.
// Ready depends on state only, so there is no combinational path from the read side.
module inst_queue_fifo_ctrl #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AFULL_LVL = 6
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     wr_valid_i,
    input  logic                     rd_ready_i,
    output logic                     wr_ready_o,
    output logic                     almost_full_o,
    output logic                     rd_valid_o,
    output logic                     push_o,
    output logic [$clog2(DEPTH)-1:0] rd_ptr_o,
    output logic [$clog2(DEPTH)-1:0] wr_ptr_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
    localparam logic [PtrW:0] CntOne = (PtrW + 1)'(1);
    localparam logic [PtrW:0] CntFull = (PtrW + 1)'(DEPTH);
    localparam logic [PtrW:0] CntAfull = (PtrW + 1)'(AFULL_LVL);

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            full, empty, push, pop;

    assign full  = (count_q == CntFull);
    assign empty = (count_q == '0);
    assign push  = wr_valid_i & ~full & ~flush_i;
    assign pop   = ~empty & rd_ready_i & ~flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
            if (push && !pop) count_d = count_q + CntOne;
            if (pop && !push) count_d = count_q - CntOne;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ready_o    = ~full;
    assign almost_full_o = (count_q >= CntAfull);
    assign rd_valid_o    = ~empty;
    assign push_o        = push;
    assign rd_ptr_o      = rd_ptr_q;
    assign wr_ptr_o      = wr_ptr_q;

endmodule

// File: rtl/inst_queue.sv
// Decoupling FIFO between IF and ID: fetched inst + PC + prediction metadata.
// Head is presented combinationally and forced to zero (nop) whenever the queue is empty.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AFULL_LVL = 6
) (
    input logic         clk,
    input logic         rst,
    input logic         flush,
    inst_queue_if.slave bus
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic            push, rd_valid;
    logic [PtrW-1:0] rd_ptr, wr_ptr;
    iq_entry_t       mem_q [DEPTH];
    iq_entry_t       mem_d [DEPTH];
    iq_entry_t       wr_entry, head;

    inst_queue_fifo_ctrl #(
        .DEPTH    (DEPTH),
        .AFULL_LVL(AFULL_LVL)
    ) u_ctrl (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .wr_valid_i   (bus.if_valid),
        .rd_ready_i   (bus.id_ready),
        .wr_ready_o   (bus.if_ready),
        .almost_full_o(bus.if_almost_full),
        .rd_valid_o   (rd_valid),
        .push_o       (push),
        .rd_ptr_o     (rd_ptr),
        .wr_ptr_o     (wr_ptr)
    );

    always_comb begin
        wr_entry.pht_index    = bus.if_pht_index;
        wr_entry.branch_taken = bus.if_branch_taken;
        wr_entry.inst         = bus.if_inst;
        wr_entry.pc           = bus.if_pc;
        mem_d = mem_q;
        if (push) mem_d[wr_ptr] = wr_entry;
    end

    // Storage carries no reset; stale contents never reach the outputs.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        head = '0;
        if (rd_valid) head = mem_q[rd_ptr];
    end

    assign bus.id_valid        = rd_valid;
    assign bus.id_pc           = head.pc;
    assign bus.id_inst         = head.inst;
    assign bus.id_branch_taken = head.branch_taken;
    assign bus.id_pht_index    = head.pht_index;

endmodule
